// File: rtl/lbuf_rd_if.sv
// Line-buffer read side bundle: lock controls in, raster timing
// and line-buffer read address out.
interface lbuf_rd_if;
    logic        frame_start_in;
    logic        lock_en;
    logic [10:0] hcnt_ext;
    logic [10:0] vcnt_ext;
    logic [8:0]  hcnt_ext_lbuf;
    logic [5:0]  vcnt_ext_lbuf;
    logic        HSYNC_ext;
    logic        VSYNC_ext;
    logic        DE_ext;
    logic        locked;
    logic        lock_lost;

    modport master (
        input  frame_start_in,
        input  lock_en,
        output hcnt_ext,
        output vcnt_ext,
        output hcnt_ext_lbuf,
        output vcnt_ext_lbuf,
        output HSYNC_ext,
        output VSYNC_ext,
        output DE_ext,
        output locked,
        output lock_lost
    );

    modport slave (
        output frame_start_in,
        output lock_en,
        input  hcnt_ext,
        input  vcnt_ext,
        input  hcnt_ext_lbuf,
        input  vcnt_ext_lbuf,
        input  HSYNC_ext,
        input  VSYNC_ext,
        input  DE_ext,
        input  locked,
        input  lock_lost
    );
endinterface

// File: rtl/lbuf_rd_scheduler.sv
// Output raster generator and line-buffer read addressing with
// optional frame lock to the input frame start.
module lbuf_rd_scheduler #(
    parameter int H_TOTAL          = 1650,
    parameter int H_SYNCLEN        = 40,
    parameter int H_AVIDSTART      = 260,
    parameter int H_ACTIVE         = 1280,
    parameter int V_TOTAL          = 750,
    parameter int V_SYNCLEN        = 5,
    parameter int V_AVIDSTART      = 25,
    parameter int V_ACTIVE         = 720,
    parameter int H_NUM            = 3,
    parameter int H_DEN            = 10,
    parameter int V_NUM            = 14,
    parameter int V_DEN            = 45,
    parameter int NUM_LINE_BUFFERS = 40,
    parameter int LB_WIDTH         = 384,
    parameter int LOCK_TIMEOUT     = 64
) (
    input  logic      PCLK_ext,
    input  logic      reset_n,
    lbuf_rd_if.master bus
);

    localparam int HACC_W = $clog2(H_DEN) + 1;
    localparam int VACC_W = $clog2(V_DEN) + 1;
    localparam int WL_W   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_END = 11'(H_SYNCLEN);
    localparam logic [10:0] VS_END = 11'(V_SYNCLEN);
    localparam logic [10:0] HA_BEG = 11'(H_AVIDSTART);
    localparam logic [10:0] HA_END = 11'(H_AVIDSTART + H_ACTIVE);
    localparam logic [10:0] HA_PRE = 11'(H_AVIDSTART - 1);
    localparam logic [10:0] VA_BEG = 11'(V_AVIDSTART);
    localparam logic [10:0] VA_END = 11'(V_AVIDSTART + V_ACTIVE);
    localparam logic [10:0] VA_PRE = 11'(V_AVIDSTART - 1);

    localparam logic [HACC_W-1:0] H_STEP = HACC_W'(H_NUM);
    localparam logic [HACC_W-1:0] H_MOD  = HACC_W'(H_DEN);
    localparam logic [VACC_W-1:0] V_STEP = VACC_W'(V_NUM);
    localparam logic [VACC_W-1:0] V_MOD  = VACC_W'(V_DEN);

    localparam logic [8:0]      LB_LAST   = 9'(LB_WIDTH - 1);
    localparam logic [5:0]      SLOT_LAST = 6'(NUM_LINE_BUFFERS - 1);
    localparam logic [WL_W-1:0] WL_LAST   = WL_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        FREERUN,
        WAIT_START,
        RUN
    } state_t;

    state_t state, state_n;

    logic [10:0]       hcnt, hcnt_n, hcnt_adv;
    logic [10:0]       vcnt, vcnt_n, vcnt_adv;
    logic [10:0]       wclk, wclk_n;
    logic [WL_W-1:0]   wline, wline_n;
    logic [HACC_W-1:0] hacc, hsum;
    logic [VACC_W-1:0] vacc, vsum;
    logic [8:0]        hlb;
    logic [5:0]        vlb;
    logic              hs, vs, de;
    logic              hs_n, vs_n, de_n;
    logic              locked, locked_n;
    logic              lost, lost_n;
    logic              line_end, frame_end;
    logic              timeout, act_line;

    assign line_end  = (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);
    assign timeout   = (wclk == H_LAST) && (wline == WL_LAST);
    assign act_line  = (vcnt >= VA_BEG) && (vcnt < VA_END);

    assign hcnt_adv = line_end ? 11'd0 : hcnt + 11'd1;
    assign vcnt_adv = !line_end ? vcnt :
                      (vcnt == V_LAST) ? 11'd0 : vcnt + 11'd1;

    assign hsum = hacc + H_STEP;
    assign vsum = vacc + V_STEP;

    always_comb begin
        state_n  = state;
        hcnt_n   = hcnt_adv;
        vcnt_n   = vcnt_adv;
        locked_n = locked;
        lost_n   = lost;
        wclk_n   = '0;
        wline_n  = '0;
        unique case (state)
            FREERUN: begin
                if (frame_end && bus.lock_en) begin
                    state_n = WAIT_START;
                    hcnt_n  = hcnt;
                    vcnt_n  = vcnt;
                end
            end
            RUN: begin
                if (frame_end && bus.lock_en) begin
                    state_n = WAIT_START;
                    hcnt_n  = hcnt;
                    vcnt_n  = vcnt;
                end else if (frame_end) begin
                    state_n  = FREERUN;
                    locked_n = 1'b0;
                end
            end
            WAIT_START: begin
                // Park on the last frame clock: syncs idle, DE low.
                hcnt_n  = hcnt;
                vcnt_n  = vcnt;
                wclk_n  = (wclk == H_LAST) ? 11'd0 : wclk + 11'd1;
                wline_n = (wclk == H_LAST) ? wline + 1'b1 : wline;
                if (!bus.lock_en) begin
                    state_n  = FREERUN;
                    hcnt_n   = '0;
                    vcnt_n   = '0;
                    locked_n = 1'b0;
                end else if (bus.frame_start_in) begin
                    state_n  = RUN;
                    hcnt_n   = '0;
                    vcnt_n   = '0;
                    locked_n = 1'b1;
                end else if (timeout) begin
                    state_n  = FREERUN;
                    hcnt_n   = '0;
                    vcnt_n   = '0;
                    locked_n = 1'b0;
                    lost_n   = 1'b1;
                end
            end
            default: begin
                state_n = FREERUN;
            end
        endcase
    end

    // Decode from next counters so the registered outputs line up.
    assign hs_n = (hcnt_n >= HS_END);
    assign vs_n = (vcnt_n >= VS_END);
    assign de_n = (hcnt_n >= HA_BEG) && (hcnt_n < HA_END) &&
                  (vcnt_n >= VA_BEG) && (vcnt_n < VA_END);

    always_ff @(posedge PCLK_ext or negedge reset_n) begin
        if (!reset_n) begin
            state  <= FREERUN;
            hcnt   <= '0;
            vcnt   <= '0;
            wclk   <= '0;
            wline  <= '0;
            hs     <= 1'b1;
            vs     <= 1'b1;
            de     <= 1'b0;
            locked <= 1'b0;
            lost   <= 1'b0;
        end else begin
            state  <= state_n;
            hcnt   <= hcnt_n;
            vcnt   <= vcnt_n;
            wclk   <= wclk_n;
            wline  <= wline_n;
            hs     <= hs_n;
            vs     <= vs_n;
            de     <= de_n;
            locked <= locked_n;
            lost   <= lost_n;
        end
    end

    always_ff @(posedge PCLK_ext or negedge reset_n) begin
        if (!reset_n) begin
            hacc <= '0;
            hlb  <= '0;
        end else if (hcnt == HA_PRE) begin
            hacc <= '0;
            hlb  <= '0;
        end else if (de) begin
            if (hsum >= H_MOD) begin
                hacc <= hsum - H_MOD;
                if (hlb != LB_LAST) begin
                    hlb <= hlb + 9'd1;
                end
            end else begin
                hacc <= hsum;
            end
        end
    end

    always_ff @(posedge PCLK_ext or negedge reset_n) begin
        if (!reset_n) begin
            vacc <= '0;
            vlb  <= '0;
        end else if (line_end && vcnt == VA_PRE) begin
            vacc <= '0;
            vlb  <= '0;
        end else if (line_end && act_line) begin
            if (vsum >= V_MOD) begin
                vacc <= vsum - V_MOD;
                vlb  <= (vlb == SLOT_LAST) ? 6'd0 : vlb + 6'd1;
            end else begin
                vacc <= vsum;
            end
        end
    end

    assign bus.hcnt_ext      = hcnt;
    assign bus.vcnt_ext      = vcnt;
    assign bus.hcnt_ext_lbuf = hlb;
    assign bus.vcnt_ext_lbuf = vlb;
    assign bus.HSYNC_ext     = hs;
    assign bus.VSYNC_ext     = vs;
    assign bus.DE_ext        = de;
    assign bus.locked        = locked;
    assign bus.lock_lost     = lost;

endmodule

// File: tb/tb_lbuf_rd_scheduler.sv
// Bench for lbuf_rd_scheduler on a reduced raster (64x60, 40x45
// active, 12-pixel slots, 5 slots, 4-line lock timeout).
module tb_lbuf_rd_scheduler;

    logic PCLK_ext;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    lbuf_rd_if bus();

    lbuf_rd_scheduler #(
        .H_TOTAL         (64),
        .H_SYNCLEN       (4),
        .H_AVIDSTART     (10),
        .H_ACTIVE        (40),
        .V_TOTAL         (60),
        .V_SYNCLEN       (2),
        .V_AVIDSTART     (5),
        .V_ACTIVE        (45),
        .H_NUM           (3),
        .H_DEN           (10),
        .V_NUM           (14),
        .V_DEN           (45),
        .NUM_LINE_BUFFERS(5),
        .LB_WIDTH        (12),
        .LOCK_TIMEOUT    (4)
    ) dut (
        .PCLK_ext(PCLK_ext),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        PCLK_ext = 1'b0;
        forever #5 PCLK_ext = ~PCLK_ext;
    end

    typedef struct {
        int t;
        int h;
        int v;
        int hs;
        int vs;
        int de;
        int hl;
        int vl;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK_ext);
        @(negedge PCLK_ext);
    endtask

    function automatic int at_hv(input int h, input int v);
        return (int'(bus.hcnt_ext) == h && int'(bus.vcnt_ext) == v)
               ? 1 : 0;
    endfunction

    task automatic wait_hv(input string nm, input int h, input int v,
                           input int lim);
        int found;
        found = 0;
        for (int i = 0; i < lim; i++) begin
            if (at_hv(h, v) == 1) begin
                found = 1;
                break;
            end
            step();
        end
        if (found == 0) chk(nm, 0, 1);
    endtask

    initial begin
        int t_cur;
        int n_hs, n_vs, n_de, n_vl, prev_vl;
        int held, n_wait, lk_mid;

        tbl[0]  = '{0,    0,  0,  1, 1, 0, 0,  0};
        tbl[1]  = '{1,    1,  0,  0, 0, 0, 0,  0};
        tbl[2]  = '{3,    3,  0,  0, 0, 0, 0,  0};
        tbl[3]  = '{4,    4,  0,  1, 0, 0, 0,  0};
        tbl[4]  = '{127,  63, 1,  1, 0, 0, 0,  0};
        tbl[5]  = '{128,  0,  2,  0, 1, 0, 0,  0};
        tbl[6]  = '{329,  9,  5,  1, 1, 0, 0,  0};
        tbl[7]  = '{330,  10, 5,  1, 1, 1, 0,  0};
        tbl[8]  = '{333,  13, 5,  1, 1, 1, 0,  0};
        tbl[9]  = '{334,  14, 5,  1, 1, 1, 1,  0};
        tbl[10] = '{369,  49, 5,  1, 1, 1, 11, 0};
        tbl[11] = '{370,  50, 5,  1, 1, 0, 11, 0};
        tbl[12] = '{393,  9,  6,  1, 1, 0, 11, 0};
        tbl[13] = '{575,  63, 8,  1, 1, 0, 11, 0};
        tbl[14] = '{576,  0,  9,  0, 1, 0, 11, 1};
        tbl[15] = '{1364, 20, 21, 1, 1, 1, 3,  4};
        tbl[16] = '{1428, 20, 22, 1, 1, 1, 3,  0};
        tbl[17] = '{3185, 49, 49, 1, 1, 1, 11, 3};
        tbl[18] = '{3210, 10, 50, 1, 1, 0, 0,  4};
        tbl[19] = '{3839, 63, 59, 1, 1, 0, 0,  4};
        tbl[20] = '{3840, 0,  0,  0, 0, 0, 0,  4};
        tbl[21] = '{4170, 10, 5,  1, 1, 1, 0,  0};

        reset_n            = 1'b0;
        bus.lock_en        = 1'b0;
        bus.frame_start_in = 1'b0;
        repeat (3) @(negedge PCLK_ext);
        reset_n = 1'b1;
        #1;
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_lost", int'(bus.lock_lost), 0);

        // Free-run raster against hand-derived points.
        t_cur = 0;
        for (int i = 0; i < 22; i++) begin
            while (t_cur < tbl[i].t) begin
                step();
                t_cur++;
            end
            chk($sformatf("v%0d_h", i), int'(bus.hcnt_ext), tbl[i].h);
            chk($sformatf("v%0d_v", i), int'(bus.vcnt_ext), tbl[i].v);
            chk($sformatf("v%0d_hs", i), int'(bus.HSYNC_ext), tbl[i].hs);
            chk($sformatf("v%0d_vs", i), int'(bus.VSYNC_ext), tbl[i].vs);
            chk($sformatf("v%0d_de", i), int'(bus.DE_ext), tbl[i].de);
            chk($sformatf("v%0d_hl", i),
                int'(bus.hcnt_ext_lbuf), tbl[i].hl);
            chk($sformatf("v%0d_vl", i),
                int'(bus.vcnt_ext_lbuf), tbl[i].vl);
        end

        // Whole-frame totals.
        wait_hv("wait_f0", 0, 0, 5000);
        n_hs = 0;
        n_vs = 0;
        n_de = 0;
        n_vl = 0;
        prev_vl = int'(bus.vcnt_ext_lbuf);
        for (int i = 0; i < 3840; i++) begin
            if (bus.HSYNC_ext == 1'b0) n_hs++;
            if (bus.VSYNC_ext == 1'b0) n_vs++;
            if (bus.DE_ext == 1'b1) n_de++;
            if (int'(bus.vcnt_ext_lbuf) != prev_vl) n_vl++;
            prev_vl = int'(bus.vcnt_ext_lbuf);
            step();
        end
        chk("frm_hs_low", n_hs, 240);
        chk("frm_vs_low", n_vs, 128);
        chk("frm_de", n_de, 1800);
        chk("frm_vl_chg", n_vl, 15);
        chk("frm_end_vl", int'(bus.vcnt_ext_lbuf), 4);

        // Lock acquisition after a 100-clock wait.
        bus.lock_en = 1'b1;
        wait_hv("wait_fe1", 63, 59, 5000);
        held = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (at_hv(63, 59) == 1 && bus.HSYNC_ext == 1'b1 &&
                bus.VSYNC_ext == 1'b1 && bus.DE_ext == 1'b0 &&
                bus.locked == 1'b0)
                held++;
        end
        chk("lock_hold", held, 100);
        bus.frame_start_in = 1'b1;
        step();
        bus.frame_start_in = 1'b0;
        chk("lock_h0", int'(bus.hcnt_ext), 0);
        chk("lock_v0", int'(bus.vcnt_ext), 0);
        chk("lock_on", int'(bus.locked), 1);

        // Mid-frame start pulse must not disturb the raster.
        repeat (20) step();
        bus.frame_start_in = 1'b1;
        step();
        bus.frame_start_in = 1'b0;
        chk("mid_h", int'(bus.hcnt_ext), 21);
        chk("mid_v", int'(bus.vcnt_ext), 0);
        chk("mid_lock", int'(bus.locked), 1);

        // Timeout from a locked wait: 4 lines of 64 clocks.
        wait_hv("wait_fe2", 63, 59, 5000);
        n_wait = 0;
        lk_mid = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (at_hv(0, 0) == 1) break;
            n_wait++;
            if (n_wait == 10) lk_mid = int'(bus.locked);
        end
        chk("to_cycles", n_wait, 256);
        chk("to_wait_lock", lk_mid, 1);
        chk("to_h0", int'(bus.hcnt_ext), 0);
        chk("to_v0", int'(bus.vcnt_ext), 0);
        chk("to_locked", int'(bus.locked), 0);
        chk("to_lost", int'(bus.lock_lost), 1);
        bus.lock_en = 1'b0;

        // Dropping lock_en while waiting releases at once.
        repeat (100) step();
        bus.lock_en = 1'b1;
        wait_hv("wait_fe3", 63, 59, 5000);
        repeat (5) step();
        chk("rel_held_h", int'(bus.hcnt_ext), 63);
        bus.lock_en = 1'b0;
        step();
        chk("rel_h0", int'(bus.hcnt_ext), 0);
        chk("rel_v0", int'(bus.vcnt_ext), 0);
        chk("rel_locked", int'(bus.locked), 0);
        wait_hv("wait_fe4", 63, 59, 5000);
        step();
        chk("free_wrap", at_hv(0, 0), 1);
        chk("lost_sticky", int'(bus.lock_lost), 1);

        // Async reset mid-frame.
        wait_hv("wait_rst", 30, 20, 5000);
        chk("pre_rst_de", int'(bus.DE_ext), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_h", int'(bus.hcnt_ext), 0);
        chk("ar_v", int'(bus.vcnt_ext), 0);
        chk("ar_hl", int'(bus.hcnt_ext_lbuf), 0);
        chk("ar_vl", int'(bus.vcnt_ext_lbuf), 0);
        chk("ar_hs", int'(bus.HSYNC_ext), 1);
        chk("ar_vs", int'(bus.VSYNC_ext), 1);
        chk("ar_de", int'(bus.DE_ext), 0);
        chk("ar_lost", int'(bus.lock_lost), 0);
        @(negedge PCLK_ext);
        reset_n = 1'b1;
        #1;
        chk("rel_rst_h", int'(bus.hcnt_ext), 0);
        chk("rel_rst_v", int'(bus.vcnt_ext), 0);
        step();
        chk("post_rst_h", int'(bus.hcnt_ext), 1);
        chk("post_rst_lost", int'(bus.lock_lost), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lbuf_rd_scheduler.md
Name: lbuf_rd_scheduler

Overview:
- Output-side controller for the 40-line CPS2 line buffer, running entirely in the PCLK_ext domain.
- Generates the output raster counters, HSYNC/VSYNC/DE, and the line-buffer read address (line slot plus pixel) that drives the scanconverter read port.
- Scales 384x224 source lines onto the output raster with fractional accumulators.
- Optionally frame-locks the output raster to the input frame start, with timeout fallback to free-run.

Parameters:
- H_TOTAL, 1650, output clocks per line
- H_SYNCLEN, 40, HSYNC low width in clocks
- H_AVIDSTART, 260, first active hcnt
- H_ACTIVE, 1280, active clocks per line
- V_TOTAL, 750, lines per frame
- V_SYNCLEN, 5, VSYNC low width in lines
- V_AVIDSTART, 25, first active vcnt
- V_ACTIVE, 720, active lines
- H_NUM / H_DEN, 3 / 10, source pixels per output pixel
- V_NUM / V_DEN, 14 / 45, source lines per output line
- NUM_LINE_BUFFERS, 40, line slots in the ring
- LB_WIDTH, 384, pixels per slot
- LOCK_TIMEOUT, 64, lines to wait for frame_start before giving up

Ports:
- PCLK_ext  in  1  output pixel clock; the only clock
- reset_n  in  1  asynchronous active-low reset
- frame_start_in  in  1  one-cycle pulse, input frame start, already synchronized to PCLK_ext
- lock_en  in  1  1 = frame-lock to frame_start_in, 0 = free-run
- hcnt_ext  out  11  output horizontal counter
- vcnt_ext  out  11  output vertical counter
- hcnt_ext_lbuf  out  9  line-buffer read pixel index
- vcnt_ext_lbuf  out  6  line-buffer read slot index
- HSYNC_ext  out  1  active-low hsync
- VSYNC_ext  out  1  active-low vsync
- DE_ext  out  1  data enable
- locked  out  1  high while the raster is phase-locked to input frames
- lock_lost  out  1  sticky; set when a lock timeout occurs, cleared only by reset

Behaviour:
- Reset values: all counters and addresses 0, HSYNC_ext=1, VSYNC_ext=1, DE_ext=0, locked=0, lock_lost=0, state FREERUN.
- All outputs are registered. Sync, DE and lbuf address are decoded from the same registered counters, so they are cycle-aligned with hcnt_ext/vcnt_ext.
- Raster counting:
  - hcnt wraps H_TOTAL-1 -> 0; vcnt increments on that wrap and wraps V_TOTAL-1 -> 0.
  - HSYNC_ext = 0 iff hcnt < H_SYNCLEN. VSYNC_ext = 0 iff vcnt < V_SYNCLEN.
  - DE_ext = 1 iff H_AVIDSTART <= hcnt < H_AVIDSTART+H_ACTIVE and V_AVIDSTART <= vcnt < V_AVIDSTART+V_ACTIVE.
- Horizontal address:
  - Accumulator hacc (width ceil(log2(H_DEN))+1) and hcnt_ext_lbuf are zeroed when hcnt = H_AVIDSTART-1.
  - Each DE cycle: hacc += H_NUM; if the result >= H_DEN, subtract H_DEN and increment hcnt_ext_lbuf.
  - hcnt_ext_lbuf saturates at LB_WIDTH-1 and never wraps.
- Vertical address:
  - At the line end (hcnt = H_TOTAL-1) with vcnt = V_AVIDSTART-1, vacc and vcnt_ext_lbuf are zeroed.
  - At the line end of each active line: vacc += V_NUM; on vacc >= V_DEN, subtract V_DEN and advance vcnt_ext_lbuf.
  - vcnt_ext_lbuf wraps NUM_LINE_BUFFERS-1 -> 0.
- FSM:
  - FREERUN: raster runs continuously; locked=0. At frame end (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1) with lock_en=1 -> WAIT_START.
  - WAIT_START:
    - Counters hold at H_TOTAL-1 / V_TOTAL-1, so syncs stay inactive and DE=0.
    - Wait counter counts H_TOTAL-clock periods.
    - On frame_start_in: next cycle hcnt=vcnt=0, go to RUN, locked=1.
    - After LOCK_TIMEOUT lines without frame_start_in: resume from 0,0, go to FREERUN, locked=0, lock_lost=1.
    - If frame_start_in and the timeout occur in the same cycle, frame_start_in wins.
  - RUN:
    - At frame end -> WAIT_START; locked stays 1 while waiting.
    - frame_start_in arriving mid-frame is ignored.
    - lock_en=0 takes effect at frame end: go to FREERUN, locked=0.
  - lock_en falling during WAIT_START: release immediately next cycle at 0,0 and go to FREERUN.
- Reset mid-frame: immediate return to reset values. No partial-line output after reset release; the first clock after release shows hcnt=0, vcnt=0.

Test Plan:
- Free-run, lock_en=0: HSYNC_ext low for exactly 40 of every 1650 clocks; VSYNC_ext low for 5 lines of 750; DE_ext high for 1280x720 per frame.
- Horizontal scaling: over one active line, hcnt_ext_lbuf goes 0..383 with exactly 384 distinct values, equals 0 on the first DE cycle, and ends at 383.
- Vertical scaling: vcnt_ext_lbuf advances 224 times per frame. It reads 0 on the first active line and wraps 39 -> 0, ending the frame at 224 mod 40 = 24.
- Lock acquisition:
  - Setup: lock_en=1, frame_start_in pulsed 1000 clocks after frame end.
  - Required: counters hold 1000 clocks with syncs high, then vcnt=hcnt=0 the cycle after the pulse, and locked=1.
- Lock timeout: lock_en=1 with no frame_start_in -> after 64 lines, raster restarts at 0,0, locked=0, lock_lost=1; lock_lost stays 1 until reset_n is asserted.
- Async reset asserted at hcnt=700, vcnt=300 -> all outputs return to reset values within the same cycle; after release, hcnt=0 and vcnt=0.
